// File: rtl/pla_seq_eval_if.sv
// Programming, input and result handshake bundle for pla_seq_eval.
// Optional last-term ports exist only when PLA_SEQ_EVAL_LAST_TERM_EN is defined.
interface pla_seq_eval_if #(
    parameter int N_IN  = 32,
    parameter int N_OUT = 20,
    parameter int AW    = 6
);
    logic             prog_we;
    logic [AW-1:0]    prog_addr;
    logic [N_IN-1:0]  prog_care;
    logic [N_IN-1:0]  prog_val;
    logic [N_OUT-1:0] prog_or;
    logic             prog_en;
    logic             prog_busy;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  x;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] z;
`ifdef PLA_SEQ_EVAL_LAST_TERM_EN
    logic             last_we;
    logic [AW-1:0]    last_term;

    modport master (
        output prog_we, prog_addr, prog_care, prog_val, prog_or, prog_en,
        output in_valid, x, out_ready, last_we, last_term,
        input  prog_busy, in_ready, out_valid, z
    );
    modport slave (
        input  prog_we, prog_addr, prog_care, prog_val, prog_or, prog_en,
        input  in_valid, x, out_ready, last_we, last_term,
        output prog_busy, in_ready, out_valid, z
    );
`else
    modport master (
        output prog_we, prog_addr, prog_care, prog_val, prog_or, prog_en,
        output in_valid, x, out_ready,
        input  prog_busy, in_ready, out_valid, z
    );
    modport slave (
        input  prog_we, prog_addr, prog_care, prog_val, prog_or, prog_en,
        input  in_valid, x, out_ready,
        output prog_busy, in_ready, out_valid, z
    );
`endif
endinterface

// File: rtl/pla_seq_eval.sv
// Programmable PLA evaluated one product term per cycle behind valid/ready handshakes.
// Optional macro PLA_SEQ_EVAL_LAST_TERM_EN adds a loadable last-term register.
module pla_seq_eval #(
    parameter int N_IN    = 32,
    parameter int N_OUT   = 20,
    parameter int N_TERMS = 64,
    parameter int AW      = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    pla_seq_eval_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    localparam logic [AW-1:0] LAST_ROW = AW'(N_TERMS - 1);

    state_t           state_reg;
    logic [AW-1:0]    idx_reg;
    logic [AW-1:0]    last_idx;
    logic [N_IN-1:0]  x_lat_reg;
    logic [N_OUT-1:0] acc_reg;
    logic [N_OUT-1:0] acc_next;
    logic [N_OUT-1:0] z_reg;
    logic             out_valid_reg;
    logic [N_TERMS-1:0] en_reg;

    // Row contents are read asynchronously so every EVAL cycle consumes its own row.
    logic [N_IN-1:0]  care_mem [N_TERMS];
    logic [N_IN-1:0]  val_mem  [N_TERMS];
    logic [N_OUT-1:0] or_mem   [N_TERMS];

    logic addr_ok;
    logic prog_fire;
    logic row_match;

    generate
        if (N_TERMS == (1 << AW)) begin : g_full_addr
            assign addr_ok = 1'b1;
        end else begin : g_part_addr
            assign addr_ok = (bus.prog_addr <= LAST_ROW);
        end
    endgenerate

    assign prog_fire = bus.prog_we && (state_reg == IDLE) && addr_ok;

    always_ff @(posedge clk) begin
        if (prog_fire) begin
            care_mem[bus.prog_addr] <= bus.prog_care;
            val_mem[bus.prog_addr]  <= bus.prog_val;
            or_mem[bus.prog_addr]   <= bus.prog_or;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg <= '0;
        end else if (prog_fire) begin
            en_reg[bus.prog_addr] <= bus.prog_en;
        end
    end

`ifdef PLA_SEQ_EVAL_LAST_TERM_EN
    logic [AW-1:0] last_reg;
    logic          last_ok;

    generate
        if (N_TERMS == (1 << AW)) begin : g_full_last
            assign last_ok = 1'b1;
        end else begin : g_part_last
            assign last_ok = (bus.last_term <= LAST_ROW);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= LAST_ROW;
        end else if (bus.last_we && (state_reg == IDLE)) begin
            last_reg <= last_ok ? bus.last_term : LAST_ROW;
        end
    end

    assign last_idx = last_reg;
`else
    assign last_idx = LAST_ROW;
`endif

    assign row_match = en_reg[idx_reg] &&
                       (((x_lat_reg ^ val_mem[idx_reg]) & care_mem[idx_reg]) == '0);
    assign acc_next  = acc_reg | (row_match ? or_mem[idx_reg] : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            x_lat_reg     <= '0;
            acc_reg       <= '0;
            z_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_lat_reg <= bus.x;
                        acc_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= EVAL;
                    end
                end
                EVAL: begin
                    acc_reg <= acc_next;
                    if (idx_reg == last_idx) begin
                        z_reg         <= acc_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    // No bypass: the next vector is accepted only once back in IDLE.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.prog_busy = (state_reg != IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.z         = z_reg;
endmodule

// File: tb/tb_pla_seq_eval.sv
// Self-checking bench for pla_seq_eval: table vectors, corner sequences and random
// vectors checked against a term-list reference model.
module tb_pla_seq_eval;
    localparam int N_IN    = 32;
    localparam int N_OUT   = 20;
    localparam int N_TERMS = 64;
    localparam int AW      = 6;

    typedef struct {
        logic [N_IN-1:0]  x;
        logic [N_OUT-1:0] z;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pla_seq_eval_if #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW)) bus ();

    pla_seq_eval #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int busy_bad = 0;

    logic [N_IN-1:0]  m_care [N_TERMS];
    logic [N_IN-1:0]  m_val  [N_TERMS];
    logic [N_OUT-1:0] m_or   [N_TERMS];
    bit               m_en   [N_TERMS];
    int               m_last = N_TERMS - 1;

    function automatic logic [N_OUT-1:0] model(input logic [N_IN-1:0] xv);
        logic [N_OUT-1:0] acc;
        acc = '0;
        for (int r = 0; r <= m_last; r++)
            if (m_en[r] && (((xv ^ m_val[r]) & m_care[r]) == '0))
                acc = acc | m_or[r];
        return acc;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < N_TERMS; r++) m_en[r] = 1'b0;
        m_last = N_TERMS - 1;
    endtask

    task automatic prog_row(input int a, input logic [N_IN-1:0] c, input logic [N_IN-1:0] v,
                            input logic [N_OUT-1:0] o, input logic e);
        bus.prog_we   = 1'b1;
        bus.prog_addr = AW'(a);
        bus.prog_care = c;
        bus.prog_val  = v;
        bus.prog_or   = o;
        bus.prog_en   = e;
        tick();
        bus.prog_we = 1'b0;
        m_care[a] = c;
        m_val[a]  = v;
        m_or[a]   = o;
        m_en[a]   = e;
    endtask

    task automatic send(input logic [N_IN-1:0] xv);
        int n;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            tick();
            n++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        bus.x        = xv;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.x        = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 300) begin
            tick();
            lat++;
            if (bus.prog_busy !== 1'b1) busy_bad++;
        end
        check("out_valid_wait", bus.out_valid, 1);
    endtask

    task automatic run_vec(input string name, input logic [N_IN-1:0] xv, input logic [N_OUT-1:0] exp_z);
        int lat;
        send(xv);
        wait_valid(lat);
        $display("[TB] %s x=%08h z=%05h exp=%05h lat=%0d", name, xv, bus.z, exp_z, lat);
        check({name, "_z"}, bus.z, exp_z);
        check({name, "_lat"}, lat, m_last + 1);
        tick();
        check({name, "_release"}, bus.out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        logic [N_OUT-1:0] zs;
        int lat;
        int bad;
        logic [N_IN-1:0] xr;
        int r;

        tbl[0] = '{x: 32'h0000_0001, z: 20'h80001};
        tbl[1] = '{x: 32'h0000_0003, z: 20'h80000};
        tbl[2] = '{x: 32'h0000_0000, z: 20'h80000};
        tbl[3] = '{x: 32'h0000_0005, z: 20'h80001};
        tbl[4] = '{x: 32'hFFFF_FFFD, z: 20'h80001};
        tbl[5] = '{x: 32'h0000_0002, z: 20'h80000};

        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_care = '0; bus.prog_val = '0;
        bus.prog_or = '0; bus.prog_en = 1'b0; bus.in_valid = 1'b0; bus.x = '0;
        bus.out_ready = 1'b1;
`ifdef PLA_SEQ_EVAL_LAST_TERM_EN
        bus.last_we = 1'b0; bus.last_term = '0;
`endif
        model_reset();

        // Reset state
        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_prog_busy", bus.prog_busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_z", bus.z, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Unprogrammed array yields zero after exactly N_TERMS cycles
        run_vec("empty", 32'hFFFF_FFFF, 20'h0);

        // Table vectors over rows 0 and 5
        prog_row(0, 32'h0000_0003, 32'h0000_0001, 20'h00001, 1'b1);
        prog_row(5, 32'h0000_0000, 32'h0000_0000, 20'h80000, 1'b1);
        for (int i = 0; i < 6; i++) run_vec("table", tbl[i].x, tbl[i].z);

        // Backpressure: result held, inputs refused
        bus.out_ready = 1'b0;
        send(32'h0000_0001);
        wait_valid(lat);
        check("bp_lat", lat, N_TERMS);
        zs = bus.z;
        check("bp_z", zs, 20'h80001);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.x = $urandom;
            tick();
            if (bus.out_valid !== 1'b1 || bus.z !== zs || bus.in_ready !== 1'b0) bad++;
        end
        bus.in_valid = 1'b0;
        check("bp_hold", bad, 0);
        bus.out_ready = 1'b1;
        check("bp_no_bypass", bus.in_ready, 0);
        tick();
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_idle", bus.in_ready, 1);
        check("bp_z_kept", bus.z, zs);
        $display("[TB] backpressure z=%05h held 10 cycles", zs);

        // Write attempt during EVAL is ignored
        busy_bad = 0;
        send(32'h0000_0003);
        repeat (5) begin
            tick();
            if (bus.prog_busy !== 1'b1) busy_bad++;
        end
        bus.prog_we = 1'b1; bus.prog_addr = '0; bus.prog_care = '0;
        bus.prog_val = '0; bus.prog_or = 20'hFFFFF; bus.prog_en = 1'b1;
        repeat (3) begin
            tick();
            if (bus.prog_busy !== 1'b1) busy_bad++;
        end
        bus.prog_we = 1'b0;
        wait_valid(lat);
        check("evalwr_z", bus.z, model(32'h0000_0003));
        tick();
        check("evalwr_busy", busy_bad, 0);
        run_vec("evalwr_next", 32'h0000_0001, model(32'h0000_0001));

        // Asynchronous reset during EVAL
        send(32'h0000_0001);
        repeat (20) tick();
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_z", bus.z, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_vec("abort_reeval", 32'h0000_0001, 20'h0);

        // Random rows and vectors against the reference model
        for (int i = 0; i < 12; i++)
            prog_row($urandom_range(0, N_TERMS - 1), $urandom & $urandom & $urandom,
                     $urandom, N_OUT'($urandom), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, N_TERMS - 1);
            if (i[0]) xr = $urandom;
            else      xr = m_val[r] ^ ($urandom & ~m_care[r]);
            if (!i[0] && !m_en[r]) xr = $urandom;
            run_vec("random", xr, model(xr));
        end

`ifdef PLA_SEQ_EVAL_LAST_TERM_EN
        // Early termination via last_term
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick();
        prog_row(4, 32'h0, 32'h0, 20'h00010, 1'b1);
        bus.last_we = 1'b1; bus.last_term = AW'(3);
        tick();
        bus.last_we = 1'b0;
        m_last = 3;
        run_vec("last3", 32'h1234_5678, 20'h00000);
        bus.last_we = 1'b1; bus.last_term = AW'(4);
        tick();
        bus.last_we = 1'b0;
        m_last = 4;
        run_vec("last4", 32'h1234_5678, 20'h00010);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pla_seq_eval.md
Name: pla_seq_eval

Overview:
- Parametrised, programmable successor to the team's fixed combinational PLA blocks.
- The AND/OR planes are held in loadable term registers instead of hard-wired logic.
- An input vector is evaluated sequentially, one product term per cycle, and the result is returned through valid/ready handshakes.
- Sits between the bench/host programming path and downstream control logic that consumes the z vector.

Parameters:
- N_IN, 32, number of input literals x.
- N_OUT, 20, number of outputs z.
- N_TERMS, 64, number of product-term rows. Must be ≥1.
- AW, $clog2(N_TERMS), term address width. Minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- prog_we  in  1  term-row write strobe.
- prog_addr  in  AW  row index.
- prog_care  in  N_IN  1 = literal participates in the term.
- prog_val  in  N_IN  required literal value where care=1.
- prog_or  in  N_OUT  OR-plane row: outputs driven by this term.
- prog_en  in  1  row enable.
- prog_busy  out  1  high when state≠IDLE; writes are ignored while high.
- in_valid  in  1  input vector offered.
- in_ready  out  1  high only in IDLE.
- x  in  N_IN  input vector.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- z  out  N_OUT  evaluated outputs.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; in_ready=1; prog_busy=0; out_valid=0; z=0; accumulator=0; term index=0.
  - All row enable bits are cleared. care/val/or contents are don't-care after reset.
- Programming:
  - In IDLE, prog_we=1 writes row prog_addr on the clock edge.
  - Addresses ≥N_TERMS are dropped.
  - prog_we in EVAL or DONE is ignored; there is no partial write.
- Term match: row r matches when en[r]=1 and ((x_lat ^ val[r]) & care[r]) == 0.
  - A row with en=1 and care=0 matches every input (tautology).
  - A row with en=0 never matches.
- FSM:
  - IDLE: in_ready=1. On in_valid&in_ready: latch x into x_lat, clear the accumulator, set idx=0, go to EVAL.
  - EVAL: each cycle, if row idx matches, acc |= or[idx]. idx increments.
    - When idx==last (N_TERMS-1 by default), after that row's OR: z<=acc_next, out_valid<=1, go to DONE.
  - DONE: hold z and out_valid. On out_valid&out_ready: out_valid<=0, go to IDLE. z keeps its last value.
- Latency: in_valid accepted at edge T → out_valid high after edge T+N_TERMS. Throughput is one vector per N_TERMS+2 cycles when out_ready is held high.
- No input bypass: in_ready=0 in DONE even if out_ready=1 in the same cycle. A new vector is accepted on the cycle after the return to IDLE.
- Boundaries:
  - idx wraps neither way; it is reset to 0 on every acceptance.
  - N_TERMS=1: EVAL lasts one cycle.
  - x changing during EVAL has no effect (x_lat is used).
  - Reset asserted in EVAL or DONE aborts: the result is lost, out_valid drops asynchronously, and the programmed rows lose their enables.
- All outputs are driven from registers except in_ready/prog_busy, which are decoded from the state register.

Optional Feature:
- Macro: PLA_SEQ_EVAL_LAST_TERM_EN.
- Enabled:
  - Adds ports last_we (in, 1) and last_term (in, AW).
  - last_we in IDLE loads the register last_q. Reset value is N_TERMS-1. Values ≥N_TERMS are clamped to N_TERMS-1.
  - EVAL terminates after row last_q, so latency = last_q+1 cycles.
- Disabled: the ports are absent and termination is fixed at N_TERMS-1.

Test Plan:
1. Reset, no programming; send x=32'hFFFF_FFFF → z=0 returned exactly N_TERMS cycles after acceptance (64 by default).
2. Row 0: care=32'h0000_0003, val=32'h0000_0001, or=20'h00001, en=1. Row 5: care=0, or=20'h80000, en=1.
   - x=32'h1 → z=20'h80001.
   - x=32'h3 → z=20'h80000.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid.
   - z and out_valid must stay stable; in_ready=0; in_valid pulses are ignored.
   - Release → one handshake, then IDLE.
4. Program attempt during EVAL: write row 0 with or=20'hFFFFF mid-evaluation.
   - The current and next results reflect the old row 0; prog_busy=1 throughout.
5. Assert rst during EVAL at cycle 20.
   - out_valid=0 and in_ready=1 immediately.
   - A re-evaluation with no reprogramming gives z=0.
6. (With PLA_SEQ_EVAL_LAST_TERM_EN) last_term=3, tautology in row 4 with or=20'h00010.
   - Latency is 4 cycles and z=0.
   - Then set last_term=4: z=20'h00010 and latency is 5 cycles.
